// File: rtl/nonogram_pkg.sv
// Shared nonogram constants, serializer state type and row packing helper.
// Used by both the board parser and board_serializer.
package nonogram_pkg;

    localparam int MAX_ROWS = 11;
    localparam int MAX_COLS = 11;
    localparam int BYTE_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_M,
        S_HDR_N,
        S_ROW,
        S_CHK,
        S_FIN
    } ser_state_t;

    // Bytes per packed row: columns never exceed 16.
    function automatic logic [1:0] row_bytes(input logic [4:0] n);
        return (n > 5'd8) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/row_byte_select.sv
// Picks one packed byte of a board row, MSB = lowest column of the byte.
// Columns at or beyond n read as zero.
module row_byte_select #(
    parameter int MAX_ROWS = nonogram_pkg::MAX_ROWS,
    parameter int MAX_COLS = nonogram_pkg::MAX_COLS
) (
    input  logic [MAX_ROWS*MAX_COLS-1:0]    board_i,
    input  logic [$clog2(MAX_ROWS)-1:0]     row_idx_i,
    input  logic                            byte_idx_i,
    input  logic [$clog2(MAX_COLS)-1:0]     n_i,
    output logic [nonogram_pkg::BYTE_W-1:0] byte_o
);

    logic [MAX_COLS-1:0] row_bits;
    logic [15:0]         cols;

    assign row_bits = MAX_COLS'(board_i >> (int'(row_idx_i) * MAX_COLS));

    always_comb begin
        cols = '0;
        for (int c = 0; c < MAX_COLS; c++) begin
            cols[c] = row_bits[c] & (c < int'(n_i));
        end
    end

    always_comb begin
        byte_o = '0;
        for (int b = 0; b < 8; b++) begin
            byte_o[7-b] = byte_idx_i ? cols[8+b] : cols[b];
        end
    end

endmodule

// File: rtl/board_serializer.sv
// Streams a captured board as m, n, then packed rows over valid/ready.
// Define BOARD_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte.
module board_serializer #(
    parameter int MAX_ROWS = nonogram_pkg::MAX_ROWS,
    parameter int MAX_COLS = nonogram_pkg::MAX_COLS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0]    solution,
    input  logic [$clog2(MAX_ROWS)-1:0]     m,
    input  logic [$clog2(MAX_COLS)-1:0]     n,
    input  logic                            tx_ready,
    output logic                            byte_valid,
    output logic [nonogram_pkg::BYTE_W-1:0] byte_out,
    output logic                            busy,
    output logic                            done
);

    import nonogram_pkg::*;

    localparam int MW = $clog2(MAX_ROWS);
    localparam int NW = $clog2(MAX_COLS);
    localparam int SW = MAX_ROWS * MAX_COLS;

    localparam logic [MW-1:0] M_CAP = MW'(MAX_ROWS);
    localparam logic [NW-1:0] N_CAP = NW'(MAX_COLS);

`ifdef BOARD_SERIALIZER_CHECKSUM_EN
    localparam ser_state_t TAIL = S_CHK;
`else
    localparam ser_state_t TAIL = S_FIN;
`endif

    ser_state_t state_q, state_d;

    logic [SW-1:0]     sol_q;
    logic [MW-1:0]     m_q;
    logic [NW-1:0]     n_q;
    logic [MW-1:0]     row_q, row_d;
    logic              byte_q, byte_d;
    logic [BYTE_W-1:0] row_byte;
    logic              capture;
    logic              xfer;
    logic              empty;
    logic              two_b;
    logic              last_byte;

`ifdef BOARD_SERIALIZER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_q, chk_d;
`endif

    assign capture   = (state_q == S_IDLE) && valid_in;
    assign xfer      = byte_valid && tx_ready;
    assign empty     = (m_q == '0) || (n_q == '0);
    assign two_b     = (row_bytes(5'(n_q)) == 2'd2);
    assign last_byte = (row_q == m_q - MW'(1)) && (byte_q || !two_b);

    row_byte_select #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS)
    ) u_sel (
        .board_i    (sol_q),
        .row_idx_i  (row_q),
        .byte_idx_i (byte_q),
        .n_i        (n_q),
        .byte_o     (row_byte)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        byte_d  = byte_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    state_d = S_HDR_M;
                    row_d   = '0;
                    byte_d  = 1'b0;
                end
            end
            S_HDR_M: if (xfer) state_d = S_HDR_N;
            S_HDR_N: if (xfer) state_d = empty ? TAIL : S_ROW;
            S_ROW: begin
                if (xfer) begin
                    if (last_byte) begin
                        state_d = TAIL;
                    end else if (two_b && !byte_q) begin
                        byte_d = 1'b1;
                    end else begin
                        byte_d = 1'b0;
                        row_d  = row_q + MW'(1);
                    end
                end
            end
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
            S_CHK: if (xfer) state_d = S_FIN;
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BOARD_SERIALIZER_CHECKSUM_EN
    always_comb begin
        chk_d = chk_q;
        if (capture) begin
            chk_d = '0;
        end else if (xfer) begin
            chk_d = chk_q ^ byte_out;
        end
    end
`endif

    always_comb begin
        byte_valid = 1'b0;
        byte_out   = '0;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FIN);
        unique case (state_q)
            S_HDR_M: begin
                byte_valid = 1'b1;
                byte_out   = BYTE_W'(m_q);
            end
            S_HDR_N: begin
                byte_valid = 1'b1;
                byte_out   = BYTE_W'(n_q);
            end
            S_ROW: begin
                byte_valid = 1'b1;
                byte_out   = row_byte;
            end
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
            S_CHK: begin
                byte_valid = 1'b1;
                byte_out   = chk_q;
            end
`endif
            default: begin
                byte_valid = 1'b0;
                byte_out   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            byte_q  <= 1'b0;
            sol_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            byte_q  <= byte_d;
            if (capture) begin
                sol_q <= solution;
                m_q   <= (m > M_CAP) ? M_CAP : m;
                n_q   <= (n > N_CAP) ? N_CAP : n;
            end
        end
    end

`ifdef BOARD_SERIALIZER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

endmodule

// File: doc/board_serializer.md
# board_serializer

Transmit-side counterpart of the board parser. It captures a solved board and its dimensions in one cycle. It then emits a framed byte stream over a valid/ready handshake to the UART transmit path: dimensions first, then the rows packed into bytes. It sits between the solver output and the UART transmitter, clocked on the 50 MHz system clock.

## Interface
- `MAX_ROWS`, default 11: maximum board rows.
- `MAX_COLS`, default 11: maximum board columns. The design supports at most 16 columns, so a row is at most 2 bytes.
- `clk`  in  1: system clock.
- `rst`  in  1: reset. Asynchronous, active-low.
- `valid_in`  in  1: one-cycle pulse; capture `solution`, `m`, `n`.
- `solution`  in  MAX_ROWS*MAX_COLS: cell (r,c) is at bit r*MAX_COLS+c. 1 means filled.
- `m`  in  $clog2(MAX_ROWS): row count.
- `n`  in  $clog2(MAX_COLS): column count.
- `tx_ready`  in  1: transmitter can accept a byte.
- `byte_valid`  out  1: `byte_out` holds a byte for the transmitter.
- `byte_out`  out  8: stream byte.
- `busy`  out  1: a board is captured or being sent.
- `done`  out  1: one-cycle pulse after the last byte is accepted.

## Operation
- Stream order:
  - byte 0 = m, zero-extended.
  - byte 1 = n, zero-extended.
  - Then rows 0..m-1. Each row is B = ceil(n/8) bytes: 1 byte if n≤8, otherwise 2.
  - Row byte k holds columns 8k..8k+7, MSB first. Column 8k is bit 7.
  - Columns ≥ n within a byte are sent as 0.
- Total length is 2 + m·B bytes, plus 1 when the checksum is enabled.
- Saturation: at capture, m > MAX_ROWS saturates to MAX_ROWS and n > MAX_COLS saturates to MAX_COLS. Bytes 0 and 1 carry the saturated values.
- m = 0 or n = 0: only the two header bytes are sent (plus checksum if enabled), then `done`.
- Capture rule: `valid_in` is accepted only in IDLE. It is ignored while `busy`, and the captured board is unaffected.
- State machine:
  - IDLE: on `valid_in`, go to HDR_M.
  - HDR_M: go to HDR_N.
  - HDR_N: go to ROW, or to CHK/FIN if m=0 or n=0.
  - ROW: loops over row and byte indices. After the last byte, go to CHK if enabled, otherwise FIN.
  - CHK: go to FIN.
  - FIN: go to IDLE.
- Advancing: each non-IDLE, non-FIN state advances only on a transfer, i.e. a cycle where `byte_valid` and `tx_ready` are both high.
- Counters: `row_idx` counts 0..m-1 and `byte_idx` counts 0..B-1. Both clear on capture and do not wrap past the final values.

## Timing
- Reset values: `byte_valid`=0, `byte_out`=0, `busy`=0, `done`=0, state IDLE, counters 0, captured registers 0.
- `valid_in` high in IDLE at cycle t:
  - From t+1: `busy`=1, `byte_valid`=1, `byte_out`=m.
- `byte_valid` stays high and `byte_out` stays stable until a transfer. The next byte appears the cycle after the transfer.
- `byte_valid` never deasserts without a transfer.
- With `tx_ready` held high, throughput is 1 byte per cycle.
- Last transfer at cycle u:
  - u+1: `done`=1 and `byte_valid`=0.
  - u+2: `busy`=0. A new `valid_in` is accepted from u+2 on.
- `valid_in` in the same cycle as `done` is ignored.
- `tx_ready` is sampled every cycle. It may toggle arbitrarily, and a transfer occurs only when both signals are high.
- Reset asserted mid-stream: all outputs clear immediately (asynchronous). No `done` is produced and the partial board is discarded.

## Configuration
- `BOARD_SERIALIZER_CHECKSUM_EN` defined:
  - After the last row byte, CHK emits one byte equal to the XOR of every prior byte in the stream, headers included.
  - The checksum accumulator clears on capture.
- Not defined: CHK and the accumulator are absent. FIN follows the last row byte (or the header when m=0 or n=0).

## Structure
- The shared package `nonogram_pkg` holds:
  - `MAX_ROWS`, `MAX_COLS`.
  - `BYTE_W`=8.
  - The serializer state enum `ser_state_t`.
  - A function `row_bytes(n)` returning B.
  - The parser uses the same package constants.
- Sub-module `row_byte_select` (combinational): given the captured board, `row_idx`, `byte_idx` and `n`, it returns the masked, MSB-first packed byte.

## Test plan
- 3×3 board, rows 101/010/111, `tx_ready`=1: bytes 03, 03, A0, 40, E0; `done` one cycle after E0. With checksum enabled, a 6th byte 03^03^A0^40^E0 = 00.
- 11×11 all filled: 2+22 bytes. Each row is FF, E0. Back-to-back transfers, and `done` at transfer 24+1.
- `tx_ready` toggled randomly: byte sequence identical to the steady-ready case, and `byte_out` never changes while `byte_valid`=1 and `tx_ready`=0.
- m=0, n=5: bytes 00, 05, then `done`. A second `valid_in` mid-stream is ignored and the sequence is unchanged.
- n=8, m=2, rows FF/81: bytes 02, 08, FF, 81 (one byte per row). m=15 input saturates: first byte 0B.
- Reset asserted after byte 3 of a 3×3 stream: outputs clear the same cycle, no `done`. A new `valid_in` then restarts from the header.
